// File: rtl/wb_stage_nx_pkg.sv
// Shared lane layout, trace entry layout and stall encodings for the writeback stage.
package wb_stage_nx_pkg;

   localparam int LANE_W    = 137;
   localparam int RF_LANE_W = 38;
   localparam int TRACE_W   = 73;
   localparam int STALL_W   = 6;

   // Field offsets (LSB position) within one lane payload, MSB first: valid..lo_wdata.
   localparam int OFF_VALID    = 136;
   localparam int OFF_PC       = 104;
   localparam int OFF_RF_WE    = 103;
   localparam int OFF_RF_WADDR = 98;
   localparam int OFF_RF_WDATA = 66;
   localparam int OFF_HI_WE    = 65;
   localparam int OFF_LO_WE    = 64;
   localparam int OFF_HI_WDATA = 32;
   localparam int OFF_LO_WDATA = 0;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

endpackage

// File: rtl/wb_stage_nx_trace_fifo.sv
// Debug trace FIFO: up to LANES compacted pushes per cycle, one registered pop per cycle.
module wb_trace_fifo
   import wb_stage_nx_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LANES-1:0]           push_vld_i,
   input  logic [LANES*TRACE_W-1:0]   push_data_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [TRACE_W-1:0]         pop_data_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [TRACE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q;
   logic [CNT_W-1:0]   count_q, count_d, npush;
   logic [PTR_W-1:0]   slot [LANES];
   logic [TRACE_W-1:0] data_q;
   logic               pop;

   // Valid lanes are packed into consecutive slots so invalid lanes leave no holes.
   always_comb begin
      npush = '0;
      for (int i = 0; i < LANES; i++) begin
         slot[i] = wptr_q + npush[PTR_W-1:0];
         if (push_vld_i[i]) npush = npush + CNT_W'(1);
      end
      pop     = (count_q != '0);
      wptr_d  = wptr_q + npush[PTR_W-1:0];
      count_d = count_q + npush - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (push_vld_i[i]) mem_q[slot[i]] <= push_data_i[i*TRACE_W +: TRACE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         count_q <= count_d;
         if (pop) begin
            data_q <= mem_q[rptr_q];
            rptr_q <= rptr_q + PTR_W'(1);
         end else begin
            data_q <= '0;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (int'(npush) <= DEPTH - int'(count_q));
      end
   end

   assign count_o    = count_q;
   assign pop_data_o = data_q;

endmodule

// File: rtl/wb_stage_nx.sv
// Writeback stage: lane pipeline register, RF write bus, HI/LO update and debug trace output.
module wb_stage_nx
   import wb_stage_nx_pkg::*;
#(
   parameter int LANES       = 2,
   parameter int TRACE_DEPTH = 8,
   parameter int LANE_W      = wb_stage_nx_pkg::LANE_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [STALL_W-1:0]          stall,
   input  logic [LANES*LANE_W-1:0]     mem_to_wb_bus,
   output logic [LANES*RF_LANE_W-1:0]  wb_to_rf_bus,
   output logic [31:0]                 hi_q,
   output logic [31:0]                 lo_q,
   output logic                        stallreq_wb,
   output logic [31:0]                 debug_wb_pc,
   output logic [3:0]                  debug_wb_rf_wen,
   output logic [4:0]                  debug_wb_rf_wnum,
   output logic [31:0]                 debug_wb_rf_wdata
);

   logic [LANES*LANE_W-1:0]    payload_q, payload_d;
   logic                       fresh_q, fresh_d;
   logic [31:0]                hi_d, lo_d;
   logic [LANE_W-1:0]          lane;
   logic [LANES-1:0]           push_vld;
   logic [LANES*TRACE_W-1:0]   push_data;
   logic [$clog2(TRACE_DEPTH):0] fifo_count;
   logic [TRACE_W-1:0]         trace_data;
   int                         pending;
   logic                       unused_stall;

   assign unused_stall = ^stall[3:0];

   always_comb begin
      payload_d = payload_q;
      fresh_d   = 1'b0;
      if (flush) begin
         payload_d = '0;
      end else if (stall[4] == STOP && stall[5] == NOSTOP) begin
         payload_d = '0;
      end else if (stall[4] == NOSTOP) begin
         payload_d = mem_to_wb_bus;
         fresh_d   = 1'b1;
      end
   end

   // Later lanes override earlier ones, so the youngest HI/LO writer wins.
   always_comb begin
      wb_to_rf_bus = '0;
      push_vld     = '0;
      push_data    = '0;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pending      = 0;
      lane         = '0;
      for (int i = 0; i < LANES; i++) begin
         lane = payload_q[i*LANE_W +: LANE_W];
         wb_to_rf_bus[i*RF_LANE_W +: RF_LANE_W] = {lane[OFF_VALID] & lane[OFF_RF_WE],
                                                   lane[OFF_RF_WADDR +: 5],
                                                   lane[OFF_RF_WDATA +: 32]};
         push_vld[i] = fresh_q & lane[OFF_VALID];
         push_data[i*TRACE_W +: TRACE_W] = {lane[OFF_PC +: 32], {4{lane[OFF_RF_WE]}},
                                            lane[OFF_RF_WADDR +: 5], lane[OFF_RF_WDATA +: 32]};
         if (push_vld[i]) begin
            pending = pending + 1;
            if (lane[OFF_HI_WE]) hi_d = lane[OFF_HI_WDATA +: 32];
            if (lane[OFF_LO_WE]) lo_d = lane[OFF_LO_WDATA +: 32];
         end
      end
      stallreq_wb = (int'(fifo_count) + pending) > (TRACE_DEPTH - LANES);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         payload_q <= '0;
         fresh_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         payload_q <= payload_d;
         fresh_q   <= fresh_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   wb_trace_fifo #(
      .LANES (LANES),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_vld_i  (push_vld),
      .push_data_i (push_data),
      .count_o     (fifo_count),
      .pop_data_o  (trace_data)
   );

   assign {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} = trace_data;

endmodule

// File: doc/wb_stage_nx.md
WB_STAGE_NX -- requirements
Module: wb_stage_nx

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes retired per cycle (1..4).
REQ-002 Parameter TRACE_DEPTH, default 8, debug trace FIFO entries; SHALL be >= 2*LANES and a power of two.
REQ-003 Parameter LANE_W, default 137, per-lane payload width: {valid, pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0], hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}, MSB first.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  pipeline flush.
REQ-007 stall  in  StallBus  pipeline stall vector; bit 4 is this stage, bit 5 the stage after.
REQ-008 mem_to_wb_bus  in  LANES*LANE_W  lane payloads; lane 0 is oldest in program order.
REQ-009 wb_to_rf_bus  out  LANES*38  per lane {rf_we, rf_waddr, rf_wdata}, lane 0 in the low bits.
REQ-010 hi_q, lo_q  out  32 each  architectural HI/LO registers.
REQ-011 stallreq_wb  out  1  request to stall upstream (trace FIFO back-pressure).
REQ-012 debug_wb_pc/_rf_wen/_rf_wnum/_rf_wdata  out  32/4/5/32  one trace entry per cycle.

Function
REQ-013 Pipeline register update priority: rst, then flush, both clearing it to zero; stall[4]=Stop with stall[5]=NoStop SHALL load a bubble (all zero); stall[4]=NoStop SHALL load mem_to_wb_bus; otherwise it SHALL hold.
REQ-014 A "fresh" flag SHALL be set on a load of mem_to_wb_bus and cleared on every other edge, including bubble loads, holds, flush and rst.
REQ-015 wb_to_rf_bus lane i SHALL be {valid_i & rf_we_i, rf_waddr_i, rf_wdata_i} of the registered payload, combinationally, every cycle.
REQ-016 HI/LO SHALL update only in fresh cycles, one edge after load; per register, the highest-index valid lane asserting its write enable wins.
REQ-017 In a fresh cycle, each valid lane SHALL push {pc, {4{rf_we}}, rf_waddr, rf_wdata} into the trace FIFO, lane 0 first; invalid lanes push nothing.
REQ-018 FIFO SHALL pop one entry per cycle when non-empty; debug_wb_* SHALL be registered from the popped entry, so a pushed entry appears no earlier than the next cycle.
REQ-019 When the FIFO is empty, debug_wb_* SHALL be all zero for that cycle.
REQ-020 Simultaneous push and pop SHALL be legal; count' = count + pushes - pop.
REQ-021 stallreq_wb SHALL equal (count + pending) > TRACE_DEPTH - LANES, where pending = valid lanes in a fresh cycle, else 0; pops are ignored.
REQ-022 A push exceeding free space is illegal; the design SHALL include a simulation assertion for it.
REQ-023 Flush SHALL NOT discard trace FIFO contents; only rst clears them.
REQ-024 FIFO read and write pointers SHALL wrap modulo TRACE_DEPTH.

Reset
REQ-025 On rst the SHALL clear: pipeline register, fresh, hi_q, lo_q, FIFO pointers and count, and debug_wb_* registers, all to 0; stallreq_wb 0 in the following cycle.
REQ-026 rst asserted mid-drain SHALL drop all queued trace entries, with no partial output.

Structure
REQ-027 LANE_W, the lane field offsets, 38-bit RF lane width and Stop/NoStop encodings SHALL live in the shared defines package.
REQ-028 The trace FIFO SHALL be a sub-module, wb_trace_fifo (multi-push up to LANES, single-pop), instantiated once.

Verification
REQ-029 LANES=2: load lane0 {pc 0xBFC00000, we, r3, 0x11} and lane1 {pc 0xBFC00004, we, r4, 0x22} -> RF writes next cycle; debug shows 0xBFC00000/r3 then 0xBFC00004/r4 on consecutive cycles.
REQ-030 Both lanes hi_we, hi 0xAAAA (lane0) and 0xBBBB (lane1) -> hi_q = 0xBBBB; lo_q unchanged.
REQ-031 stall=6'b010000 (bit4 Stop, bit5 NoStop) -> registered payload zero, wb_to_rf we=0, no trace push.
REQ-032 stall[4]=Stop and stall[5]=Stop for 3 cycles after a load -> exactly 2 trace entries pushed, HI/LO updated once.
REQ-033 Two valid lanes every cycle with DEPTH=8 -> stallreq_wb rises at count + pending > 6, FIFO never overflows, entries drain in order.
REQ-034 flush with 5 entries queued -> all 5 still drain; rst then -> debug outputs 0 next cycle and count 0.
